// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the DDS register slave address map and its
// configuration master: register word offsets within a channel window, AXI
// burst/response encodings, the programming step sequence and the
// per-transaction FSM states.
// -----------------------------------------------------------------------------
package dds_pkg;

  // Word offsets inside one channel's 16-word window (address bits [3:0]).
  localparam logic [3:0] REG_WAVE_SEL = 4'h0;
  localparam logic [3:0] REG_FREQ     = 4'h1;  // + store slot
  localparam logic [3:0] REG_PHASE    = 4'h5;  // + store slot
  localparam logic [3:0] REG_WR_EN    = 4'h9;
  localparam logic [3:0] REG_DATA     = 4'hA;

  localparam logic [1:0] BURST_FIXED  = 2'b00;
  localparam logic [1:0] BURST_INCR   = 2'b01;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;

  // Longest AXI burst the table write is split into.
  localparam int MAX_BURST = 256;

  typedef enum logic [2:0] {
    STEP_WAVE_SEL  = 3'd0,
    STEP_FREQ      = 3'd1,
    STEP_PHASE     = 3'd2,
    STEP_WR_EN_SET = 3'd3,
    STEP_DATA      = 3'd4,
    STEP_WR_EN_CLR = 3'd5
  } step_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Register word offset targeted by a step.
  function automatic logic [3:0] reg_offset(step_e step, logic [1:0] store);
    logic [3:0] off;
    unique case (step)
      STEP_WAVE_SEL:  off = REG_WAVE_SEL;
      STEP_FREQ:      off = REG_FREQ + {2'b00, store};
      STEP_PHASE:     off = REG_PHASE + {2'b00, store};
      STEP_DATA:      off = REG_DATA;
      default:        off = REG_WR_EN;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/dds_cfg_master_if.sv
// -----------------------------------------------------------------------------
// AXI_INF
// AXI4 port bundle used between the DDS configuration master and the DDS
// register slave. CLK/RSTN travel with the bundle and are driven by the master.
//   modport M : master view (drives AW/W, B ready, read-channel tie-offs)
//   modport S : slave view
// -----------------------------------------------------------------------------
interface AXI_INF;

  logic        CLK;
  logic        RSTN;

  // Write address channel
  logic [3:0]  WR_ADDR_ID;
  logic [31:0] WR_ADDR;
  logic [7:0]  WR_ADDR_LEN;
  logic [1:0]  WR_ADDR_BURST;
  logic        WR_ADDR_VALID;
  logic        WR_ADDR_READY;

  // Write data channel
  logic [31:0] WR_DATA;
  logic        WR_DATA_LAST;
  logic        WR_DATA_VALID;
  logic        WR_DATA_READY;

  // Write response channel
  logic [1:0]  WR_BACK_RESP;
  logic        WR_BACK_VALID;
  logic        WR_BACK_READY;

  // Read channels
  logic [3:0]  RD_ADDR_ID;
  logic [31:0] RD_ADDR;
  logic [7:0]  RD_ADDR_LEN;
  logic [1:0]  RD_ADDR_BURST;
  logic        RD_ADDR_VALID;
  logic        RD_ADDR_READY;
  logic [31:0] RD_DATA;
  logic [1:0]  RD_DATA_RESP;
  logic        RD_DATA_LAST;
  logic        RD_DATA_VALID;
  logic        RD_DATA_READY;

  modport M (
    output CLK, RSTN,
    output WR_ADDR_ID, WR_ADDR, WR_ADDR_LEN, WR_ADDR_BURST, WR_ADDR_VALID,
    input  WR_ADDR_READY,
    output WR_DATA, WR_DATA_LAST, WR_DATA_VALID,
    input  WR_DATA_READY,
    input  WR_BACK_RESP, WR_BACK_VALID,
    output WR_BACK_READY,
    output RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_BURST, RD_ADDR_VALID,
    output RD_DATA_READY
  );

  modport S (
    input  CLK, RSTN,
    input  WR_ADDR_ID, WR_ADDR, WR_ADDR_LEN, WR_ADDR_BURST, WR_ADDR_VALID,
    output WR_ADDR_READY,
    input  WR_DATA, WR_DATA_LAST, WR_DATA_VALID,
    output WR_DATA_READY,
    output WR_BACK_RESP, WR_BACK_VALID,
    input  WR_BACK_READY,
    input  RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_BURST, RD_ADDR_VALID,
    output RD_ADDR_READY,
    output RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID,
    input  RD_DATA_READY
  );

endinterface

// File: rtl/dds_cfg_master.sv
// -----------------------------------------------------------------------------
// dds_cfg_master
// AXI write master that programs one DDS channel. A single accepted command is
// turned into the ordered write sequence
//   wave_sel, freq_ctrl, phase_ctrl, wr_enable=1, table data (FIXED bursts),
//   wr_enable=0
// with the last three steps skipped when no table is supplied.
//
// Ports
//   clk, DDS_SLAVE_RSTN_SYNC   clock, asynchronous active-low reset
//   cmd_*                      command handshake and fields
//   smp_valid/ready/data       table sample stream (passed straight to W)
//   busy, done, err, err_resp  sequence status
//   AXI_M                      AXI master port (read channel tied off)
// -----------------------------------------------------------------------------
module dds_cfg_master
  import dds_pkg::*;
#(
  parameter int          CHANNEL_NUM = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter logic [3:0]  AXI_ID      = 4'h0,
  parameter int          LEN_W       = 13
) (
  input  logic             clk,
  input  logic             DDS_SLAVE_RSTN_SYNC,

  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_channel,
  input  logic [1:0]       cmd_store,
  input  logic [31:0]      cmd_freq,
  input  logic [31:0]      cmd_phase,
  input  logic [LEN_W-1:0] cmd_wave_len,

  input  logic             smp_valid,
  output logic             smp_ready,
  input  logic [31:0]      smp_data,

  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_resp,

  AXI_INF.M                AXI_M
);

  localparam logic [4:0] CH_LIMIT = 5'(CHANNEL_NUM);

  state_e           state_q, state_d;
  step_e            step_q, step_d;
  logic [3:0]       chan_q, chan_d;
  logic [1:0]       store_q, store_d;
  logic [31:0]      freq_q, freq_d;
  logic [31:0]      phase_q, phase_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [7:0]       beat_q, beat_d;
  logic [7:0]       len_q, len_d;
  logic             err_q, err_d;
  logic [1:0]       err_resp_q, err_resp_d;

  logic        aw_valid;
  logic [7:0]  aw_len;
  logic        w_valid;
  logic        w_last;
  logic        w_hs;
  logic [31:0] w_data;
  logic        resp_bad;
  step_e       nxt_step;
  logic        nxt_valid;

  // Burst length for the current step: table data is chopped into bursts of
  // at most MAX_BURST beats; every register write is a single beat.
  assign aw_len = (step_q != STEP_DATA)             ? 8'd0 :
                  (remaining_q > LEN_W'(MAX_BURST)) ? 8'(MAX_BURST - 1) :
                                                      8'(remaining_q - LEN_W'(1));

  assign aw_valid = (state_q == ST_AW);
  // Register steps always have their data on hand; the table step waits on
  // the sample stream.
  assign w_valid  = (state_q == ST_W) && ((step_q != STEP_DATA) || smp_valid);
  assign w_last   = (beat_q == len_q);
  assign w_hs     = w_valid && AXI_M.WR_DATA_READY;

  always_comb begin
    w_data = 32'h0;
    unique case (step_q)
      STEP_WAVE_SEL:  w_data = {30'h0, store_q};
      STEP_FREQ:      w_data = freq_q;
      STEP_PHASE:     w_data = phase_q;
      STEP_WR_EN_SET: w_data = 32'h1;
      STEP_DATA:      w_data = smp_data;
      default:        w_data = 32'h0;
    endcase
  end

  always_comb begin
    // NOTE: every signal assigned here gets its default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    step_d      = step_q;
    chan_d      = chan_q;
    store_d     = store_q;
    freq_d      = freq_q;
    phase_d     = phase_q;
    remaining_d = remaining_q;
    beat_d      = beat_q;
    len_d       = len_q;
    err_d       = err_q;
    err_resp_d  = err_resp_q;
    resp_bad    = 1'b0;
    nxt_step    = step_q;
    nxt_valid   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          chan_d      = cmd_channel;
          store_d     = cmd_store;
          freq_d      = cmd_freq;
          phase_d     = cmd_phase;
          remaining_d = cmd_wave_len;
          step_d      = STEP_WAVE_SEL;
          err_d       = 1'b0;
          err_resp_d  = RESP_OKAY;
          if ({1'b0, cmd_channel} >= CH_LIMIT) begin
            // Out-of-range channel: finish immediately without touching AXI.
            err_d      = 1'b1;
            err_resp_d = RESP_SLVERR;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_AW;
          end
        end
      end

      ST_AW: begin
        if (AXI_M.WR_ADDR_READY) begin
          len_d   = aw_len;
          beat_d  = 8'd0;
          state_d = ST_W;
        end
      end

      ST_W: begin
        if (w_hs) begin
          beat_d = beat_q + 8'd1;
          if (step_q == STEP_DATA) begin
            remaining_d = remaining_q - LEN_W'(1);
          end
          if (w_last) begin
            state_d = ST_B;
          end
        end
      end

      ST_B: begin
        if (AXI_M.WR_BACK_VALID) begin
          resp_bad = (AXI_M.WR_BACK_RESP != RESP_OKAY);
          if (resp_bad && !err_q) begin
            err_d      = 1'b1;
            err_resp_d = AXI_M.WR_BACK_RESP;
          end
          // Once wr_enable has been set it is always cleared again, even if a
          // later write fails, so the slave is never left in write mode.
          unique case (step_q)
            STEP_WAVE_SEL: begin
              nxt_step  = STEP_FREQ;
              nxt_valid = !resp_bad;
            end
            STEP_FREQ: begin
              nxt_step  = STEP_PHASE;
              nxt_valid = !resp_bad;
            end
            STEP_PHASE: begin
              nxt_step  = STEP_WR_EN_SET;
              nxt_valid = !resp_bad && (remaining_q != '0);
            end
            STEP_WR_EN_SET: begin
              nxt_step  = resp_bad ? STEP_WR_EN_CLR : STEP_DATA;
              nxt_valid = 1'b1;
            end
            STEP_DATA: begin
              nxt_step  = (resp_bad || (remaining_q == '0)) ? STEP_WR_EN_CLR : STEP_DATA;
              nxt_valid = 1'b1;
            end
            default: begin
              nxt_step  = step_q;
              nxt_valid = 1'b0;
            end
          endcase
          step_d  = nxt_step;
          state_d = nxt_valid ? ST_AW : ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge DDS_SLAVE_RSTN_SYNC) begin
    if (!DDS_SLAVE_RSTN_SYNC) begin
      state_q     <= ST_IDLE;
      step_q      <= STEP_WAVE_SEL;
      chan_q      <= '0;
      store_q     <= '0;
      freq_q      <= '0;
      phase_q     <= '0;
      remaining_q <= '0;
      beat_q      <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      err_resp_q  <= RESP_OKAY;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the values from before this edge, independent of order.
      state_q     <= state_d;
      step_q      <= step_d;
      chan_q      <= chan_d;
      store_q     <= store_d;
      freq_q      <= freq_d;
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
      beat_q      <= beat_d;
      len_q       <= len_d;
      err_q       <= err_d;
      err_resp_q  <= err_resp_d;
    end
  end

  // Status. Reset gates cmd_ready so nothing is accepted while held in reset.
  assign cmd_ready = (state_q == ST_IDLE) && DDS_SLAVE_RSTN_SYNC;
  assign busy      = (state_q == ST_AW) || (state_q == ST_W) || (state_q == ST_B);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign err_resp  = err_resp_q;
  assign smp_ready = (state_q == ST_W) && (step_q == STEP_DATA) && AXI_M.WR_DATA_READY;

  // AXI write channels
  assign AXI_M.CLK           = clk;
  assign AXI_M.RSTN          = DDS_SLAVE_RSTN_SYNC;
  assign AXI_M.WR_ADDR_ID    = AXI_ID;
  assign AXI_M.WR_ADDR       = BASE_ADDR + {24'h0, chan_q, reg_offset(step_q, store_q)};
  assign AXI_M.WR_ADDR_LEN   = aw_len;
  assign AXI_M.WR_ADDR_BURST = (step_q == STEP_DATA) ? BURST_FIXED : BURST_INCR;
  assign AXI_M.WR_ADDR_VALID = aw_valid;
  assign AXI_M.WR_DATA       = w_data;
  assign AXI_M.WR_DATA_LAST  = (state_q == ST_W) && w_last;
  assign AXI_M.WR_DATA_VALID = w_valid;
  assign AXI_M.WR_BACK_READY = (state_q == ST_B);

  // Read channel is unused
  assign AXI_M.RD_ADDR_ID    = AXI_ID;
  assign AXI_M.RD_ADDR       = 32'h0;
  assign AXI_M.RD_ADDR_LEN   = 8'h0;
  assign AXI_M.RD_ADDR_BURST = BURST_INCR;
  assign AXI_M.RD_ADDR_VALID = 1'b0;
  assign AXI_M.RD_DATA_READY = 1'b1;

endmodule

// File: tb/tb_dds_cfg_master.sv
// -----------------------------------------------------------------------------
// tb_dds_cfg_master
// Directed bench for dds_cfg_master: a small AXI slave model logs every
// AW/W/B handshake; each scenario compares the logged traffic and the status
// outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_dds_cfg_master;
  import dds_pkg::*;

  localparam int LEN_W = 13;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_channel = '0;
  logic [1:0]       cmd_store = '0;
  logic [31:0]      cmd_freq = '0;
  logic [31:0]      cmd_phase = '0;
  logic [LEN_W-1:0] cmd_wave_len = '0;
  logic             smp_valid = 1'b0;
  logic             smp_ready;
  logic [31:0]      smp_data = '0;
  logic             busy, done, err;
  logic [1:0]       err_resp;

  always #5 clk = ~clk;

  AXI_INF ax();

  dds_cfg_master #(
    .CHANNEL_NUM (2),
    .BASE_ADDR   (32'h4000_0000),
    .AXI_ID      (4'h0),
    .LEN_W       (LEN_W)
  ) dut (
    .clk                 (clk),
    .DDS_SLAVE_RSTN_SYNC (rst_n),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_channel         (cmd_channel),
    .cmd_store           (cmd_store),
    .cmd_freq            (cmd_freq),
    .cmd_phase           (cmd_phase),
    .cmd_wave_len        (cmd_wave_len),
    .smp_valid           (smp_valid),
    .smp_ready           (smp_ready),
    .smp_data            (smp_data),
    .busy                (busy),
    .done                (done),
    .err                 (err),
    .err_resp            (err_resp),
    .AXI_M               (ax)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; logic [1:0] burst; } aw_t;
  typedef struct { logic [31:0] data; logic last; } w_t;

  aw_t aw_q[$];
  w_t  w_q[$];

  int n_checks = 0;
  int n_errors = 0;

  bit rand_mode  = 1'b0;
  bit smp_toggle = 1'b0;
  int b_pending  = 0;
  int b_idx      = 0;
  int inject_b   = -1;
  int smp_idx    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave model and sample source: drive at negedge, log handshakes #1 later.
  initial begin
    ax.RD_ADDR_READY = 1'b0;
    ax.RD_DATA       = '0;
    ax.RD_DATA_RESP  = '0;
    ax.RD_DATA_LAST  = 1'b0;
    ax.RD_DATA_VALID = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      b_pending        = 0;
      ax.WR_ADDR_READY = 1'b0;
      ax.WR_DATA_READY = 1'b0;
      ax.WR_BACK_VALID = 1'b0;
      ax.WR_BACK_RESP  = 2'b00;
      smp_valid        = 1'b0;
    end else begin
      ax.WR_ADDR_READY = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      ax.WR_DATA_READY = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      ax.WR_BACK_VALID = (b_pending > 0) && (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
      ax.WR_BACK_RESP  = (b_idx == inject_b) ? 2'b10 : 2'b00;
      smp_valid        = smp_toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      smp_data         = 32'(smp_idx);
    end
    #1;
    if (ax.WR_ADDR_VALID === 1'b1 && ax.WR_ADDR_READY === 1'b1)
      aw_q.push_back('{ax.WR_ADDR, ax.WR_ADDR_LEN, ax.WR_ADDR_BURST});
    if (ax.WR_DATA_VALID === 1'b1 && ax.WR_DATA_READY === 1'b1) begin
      w_q.push_back('{ax.WR_DATA, ax.WR_DATA_LAST});
      if (ax.WR_DATA_LAST === 1'b1) b_pending++;
      if (smp_valid && smp_ready === 1'b1) smp_idx++;
    end
    if (ax.WR_BACK_VALID === 1'b1 && ax.WR_BACK_READY === 1'b1) begin
      b_pending--;
      b_idx++;
    end
  end

  task automatic clear_logs();
    aw_q.delete();
    w_q.delete();
    b_idx   = 0;
    smp_idx = 0;
  endtask

  task automatic send_cmd(input logic [3:0] ch, input logic [1:0] st, input logic [31:0] f,
                          input logic [31:0] p, input logic [LEN_W-1:0] len);
    int n;
    n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid    = 1'b1;
    cmd_channel  = ch;
    cmd_store    = st;
    cmd_freq     = f;
    cmd_phase    = p;
    cmd_wave_len = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  // Table region of a 300-sample sequence: w_q[4..303].
  task automatic check_table(input string pfx);
    int bad, lasts;
    bit sized;
    bad   = 0;
    lasts = 0;
    sized = (w_q.size() == 305);
    check({pfx, "_w_count"}, 32'(w_q.size()), 32'd305);
    if (sized) begin
      for (int i = 0; i < 300; i++) begin
        if (w_q[4+i].data !== 32'(i)) bad++;
        if (w_q[4+i].last === 1'b1) lasts++;
      end
    end else begin
      bad = 999;
    end
    check({pfx, "_bad_samples"}, 32'(bad), 32'd0);
    check({pfx, "_last_count"}, 32'(lasts), 32'd2);
    check({pfx, "_last_beat256"}, sized ? 32'(w_q[259].last) : 32'd0, 32'd1);
    check({pfx, "_last_beat300"}, sized ? 32'(w_q[303].last) : 32'd0, 32'd1);
  endtask

  logic [31:0] t2_addr[7]  = '{32'h4000_0010, 32'h4000_0011, 32'h4000_0015, 32'h4000_0019,
                               32'h4000_001A, 32'h4000_001A, 32'h4000_0019};
  logic [7:0]  t2_len[7]   = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd43, 8'd0};
  logic [1:0]  t2_burst[7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};

  initial begin
    int cyc;
    int n;

    // ---------------- Reset values ----------------
    #3;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_resp", 32'(err_resp), 32'd0);
    check("rst_awvalid", 32'(ax.WR_ADDR_VALID), 32'd0);
    check("rst_wvalid", 32'(ax.WR_DATA_VALID), 32'd0);
    check("rst_bready", 32'(ax.WR_BACK_READY), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // ---------------- T1: register-only sequence ----------------
    clear_logs();
    send_cmd(4'd0, 2'd2, 32'h0001_0000, 32'h0000_0400, '0);
    check("t1_busy_after_accept", 32'(busy), 32'd1);
    check("t1_no_done_early", 32'(done), 32'd0);
    wait_done("t1", 200, cyc);
    check("t1_err", 32'(err), 32'd0);
    check("t1_busy_at_done", 32'(busy), 32'd0);
    check("t1_aw_count", 32'(aw_q.size()), 32'd3);
    check("t1_w_count", 32'(w_q.size()), 32'd3);
    if (aw_q.size() == 3 && w_q.size() == 3) begin
      check("t1_addr0", aw_q[0].addr, 32'h4000_0000);
      check("t1_addr1", aw_q[1].addr, 32'h4000_0003);
      check("t1_addr2", aw_q[2].addr, 32'h4000_0007);
      check("t1_data0", w_q[0].data, 32'd2);
      check("t1_data1", w_q[1].data, 32'h0001_0000);
      check("t1_data2", w_q[2].data, 32'h0000_0400);
      check("t1_len0", 32'(aw_q[0].len), 32'd0);
      check("t1_burst1", 32'(aw_q[1].burst), 32'd1);
      check("t1_last2", 32'(w_q[2].last), 32'd1);
    end
    @(negedge clk);
    check("t1_done_one_cycle", 32'(done), 32'd0);
    check("t1_ready_again", 32'(cmd_ready), 32'd1);

    // ---------------- T2: 300-sample table, always-ready ----------------
    clear_logs();
    send_cmd(4'd1, 2'd0, 32'h1234_5678, 32'h0000_0ABC, 13'd300);
    wait_done("t2", 2000, cyc);
    check("t2_err", 32'(err), 32'd0);
    check("t2_aw_count", 32'(aw_q.size()), 32'd7);
    if (aw_q.size() == 7) begin
      for (int i = 0; i < 7; i++) begin
        check($sformatf("t2_addr%0d", i), aw_q[i].addr, t2_addr[i]);
        check($sformatf("t2_len%0d", i), 32'(aw_q[i].len), 32'(t2_len[i]));
        check($sformatf("t2_burst%0d", i), 32'(aw_q[i].burst), 32'(t2_burst[i]));
      end
    end
    check_table("t2");
    if (w_q.size() == 305) begin
      check("t2_wave_sel", w_q[0].data, 32'd0);
      check("t2_freq", w_q[1].data, 32'h1234_5678);
      check("t2_phase", w_q[2].data, 32'h0000_0ABC);
      check("t2_wren_set", w_q[3].data, 32'd1);
      check("t2_wren_clr", w_q[304].data, 32'd0);
    end

    // ---------------- T3: random readiness, bursty samples ----------------
    clear_logs();
    rand_mode  = 1'b1;
    smp_toggle = 1'b1;
    send_cmd(4'd1, 2'd3, 32'hCAFE_0001, 32'h0000_0123, 13'd300);
    wait_done("t3", 20000, cyc);
    rand_mode  = 1'b0;
    smp_toggle = 1'b0;
    check("t3_err", 32'(err), 32'd0);
    check("t3_aw_count", 32'(aw_q.size()), 32'd7);
    if (aw_q.size() == 7) begin
      check("t3_addr_freq", aw_q[1].addr, 32'h4000_0014);
      check("t3_addr_phase", aw_q[2].addr, 32'h4000_0018);
      check("t3_len_burst2", 32'(aw_q[5].len), 32'd43);
    end
    check_table("t3");

    // ---------------- T4: rejected channels ----------------
    clear_logs();
    send_cmd(4'd5, 2'd0, 32'h1, 32'h2, 13'd10);
    wait_done("t4", 20, cyc);
    check("t4_done_latency", 32'(cyc), 32'd0);
    check("t4_err", 32'(err), 32'd1);
    check("t4_err_resp", 32'(err_resp), 32'd2);
    check("t4_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("t4_no_aw", 32'(aw_q.size()), 32'd0);
    send_cmd(4'd2, 2'd0, 32'h1, 32'h2, 13'd0);
    wait_done("t4b", 20, cyc);
    check("t4b_err", 32'(err), 32'd1);
    check("t4b_err_resp", 32'(err_resp), 32'd2);
    repeat (3) @(negedge clk);
    check("t4b_no_aw", 32'(aw_q.size()), 32'd0);

    // ---------------- T5: SLVERR on first table burst ----------------
    clear_logs();
    inject_b = 4;
    send_cmd(4'd1, 2'd1, 32'h0000_0055, 32'h0000_0066, 13'd300);
    wait_done("t5", 2000, cyc);
    inject_b = -1;
    check("t5_err", 32'(err), 32'd1);
    check("t5_err_resp", 32'(err_resp), 32'd2);
    check("t5_aw_count", 32'(aw_q.size()), 32'd6);
    check("t5_w_count", 32'(w_q.size()), 32'd261);
    if (aw_q.size() == 6 && w_q.size() == 261) begin
      check("t5_burst_addr", aw_q[4].addr, 32'h4000_001A);
      check("t5_burst_len", 32'(aw_q[4].len), 32'd255);
      check("t5_clr_addr", aw_q[5].addr, 32'h4000_0019);
      check("t5_clr_data", w_q[260].data, 32'd0);
    end

    // ---------------- T6: reset in the middle of the table write ----------------
    clear_logs();
    send_cmd(4'd0, 2'd0, 32'h0000_0077, 32'h0000_0088, 13'd300);
    n = 0;
    while (w_q.size() < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_table", 32'(w_q.size() >= 10), 32'd1);
    check("t6_pre_wvalid", 32'(ax.WR_DATA_VALID), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_awvalid", 32'(ax.WR_ADDR_VALID), 32'd0);
    check("t6_rst_wvalid", 32'(ax.WR_DATA_VALID), 32'd0);
    check("t6_rst_bready", 32'(ax.WR_BACK_READY), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_smp_ready", 32'(smp_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
    send_cmd(4'd0, 2'd1, 32'h0000_AAAA, 32'h0000_0123, '0);
    wait_done("t6", 200, cyc);
    check("t6_err", 32'(err), 32'd0);
    check("t6_aw_count", 32'(aw_q.size()), 32'd3);
    if (aw_q.size() == 3 && w_q.size() == 3) begin
      check("t6_addr0", aw_q[0].addr, 32'h4000_0000);
      check("t6_addr1", aw_q[1].addr, 32'h4000_0002);
      check("t6_addr2", aw_q[2].addr, 32'h4000_0006);
      check("t6_data0", w_q[0].data, 32'd1);
      check("t6_data1", w_q[1].data, 32'h0000_AAAA);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
